// File: rtl/osecpu_pkg.sv
// Shared opcodes, FSM encodings, CR bit positions and instruction-length decode for the sequencer.
package osecpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CR_W   = 8;

  localparam logic [OP_W-1:0] OP_NOP    = 8'h00;
  localparam logic [OP_W-1:0] OP_LBSET  = 8'h01;
  localparam logic [OP_W-1:0] OP_LIMM32 = 8'h02;
  localparam logic [OP_W-1:0] OP_CND    = 8'h04;
  localparam logic [OP_W-1:0] OP_HLT    = 8'hFF;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_HALT    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  localparam int unsigned BIT_CR_HLT  = 0;
  localparam int unsigned BIT_CR_SKIP = 1;
  localparam int unsigned BIT_CR_ERR  = 2;

  // Instruction length in words, decoded from the first word's opcode.
  function automatic logic [LEN_W-1:0] op_len(input logic [OP_W-1:0] op);
    case (op)
      OP_LIMM32, OP_LBSET: op_len = LEN_W'(2);
      default:             op_len = LEN_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Memory fetch port plus execute-stage handshake between the sequencer and its neighbours.
interface seq_controller_if #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned MAX_WORDS = 2
);
  localparam int unsigned INSTR_W = 32 * MAX_WORDS;

  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic [31:0]        mem_rdata;
  logic               mem_valid;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         instr_len;
  logic               exec_valid;
  logic               exec_done;
  logic               cond_lsb;
  logic               pc_update_req;
  logic               call_req;
  logic               ret_req;
  logic [PC_W-1:0]    pc_update_addr;
  logic               resume;

  modport master (
    output mem_req, mem_addr, instr, instr_len, exec_valid,
    input  mem_rdata, mem_valid, exec_done, cond_lsb, pc_update_req,
           call_req, ret_req, pc_update_addr, resume
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_len, exec_valid,
    output mem_rdata, mem_valid, exec_done, cond_lsb, pc_update_req,
           call_req, ret_req, pc_update_addr, resume
  );
endinterface

// File: rtl/seq_controller_ras.sv
// Return-address stack: LIFO of PCs with occupancy, full and empty flags.
module ras_stack #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  stack_q [DEPTH];
  logic [LW-1:0] level_q;

  // Occupancy counter; push and pop are never requested together.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
    end else if (push && !full) begin
      level_q <= level_q + LW'(1);
    end else if (pop && !empty) begin
      level_q <= level_q - LW'(1);
    end
  end

  // Entry storage; contents above the level are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      stack_q[AW'(level_q)] <= push_data;
    end
  end

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign top   = stack_q[AW'(level_q - LW'(1))];

endmodule

// File: rtl/seq_controller.sv
// Instruction sequencer: fetches variable-length instructions, hands them to execute, owns PC/CR/RAS.
module seq_controller
  import osecpu_pkg::*;
#(
  parameter  int unsigned PC_W      = 16,
  parameter  int unsigned MAX_WORDS = 2,
  parameter  int unsigned RAS_DEPTH = 4,
  localparam int unsigned LVL_W     = $clog2(RAS_DEPTH) + 1,
  localparam int unsigned INSTR_W   = WORD_W * MAX_WORDS
) (
  input  logic             clk,
  input  logic             reset,
  seq_controller_if.master bus,
  output logic [PC_W-1:0]  pc,
  output logic [1:0]       state,
  output logic [CR_W-1:0]  cr,
  output logic [LVL_W-1:0] ras_level
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               hlt_q, hlt_d;
  logic               skip_q, skip_d;
  logic               err_q, err_d;
  logic               mem_req_q, mem_req_d;
  logic [PC_W-1:0]    mem_addr_q, mem_addr_d;
  logic               exec_valid_q, exec_valid_d;

  logic               ras_push, ras_pop;
  logic [PC_W-1:0]    ras_top;
  logic               ras_full, ras_empty;

  logic [LEN_W-1:0]   word_len_c;
  logic [LEN_W-1:0]   cur_len_c;
  logic [OP_W-1:0]    op_c;

  ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_q),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .level     (ras_level)
  );

  // Next state, datapath updates and registered-output targets.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    idx_d      = idx_q;
    instr_d    = instr_q;
    len_d      = len_q;
    hlt_d      = hlt_q;
    skip_d     = skip_q;
    err_d      = err_q;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;

    word_len_c = op_len(bus.mem_rdata[31:24]);
    if (word_len_c > LEN_W'(MAX_WORDS)) begin
      word_len_c = LEN_W'(MAX_WORDS);
    end
    cur_len_c  = (idx_q == '0) ? word_len_c : len_q;
    op_c       = instr_q[31:24];

    case (state_q)
      ST_FETCH: begin
        if (bus.mem_valid) begin
          if (idx_q == '0) begin
            instr_d        = '0;
            instr_d[31:0]  = bus.mem_rdata;
            len_d          = word_len_c;
          end else begin
            instr_d[WORD_W*idx_q +: WORD_W] = bus.mem_rdata;
          end
          pc_d = pc_q + PC_W'(1);
          if ((LEN_W'(idx_q) + LEN_W'(1)) < cur_len_c) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d = '0;
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              state_d = ST_EXEC;
            end
          end
        end
      end

      ST_EXEC: begin
        if (bus.exec_done) begin
          skip_d  = (op_c == OP_CND) && !bus.cond_lsb;
          state_d = ST_FETCH;
          if (op_c == OP_HLT) begin
            hlt_d   = 1'b1;
            state_d = ST_HALT;
          end else if (bus.call_req && bus.ret_req) begin
            err_d   = 1'b1;
            hlt_d   = 1'b1;
            state_d = ST_HALT;
          end else if (bus.ret_req) begin
            if (ras_empty) begin
              err_d   = 1'b1;
              hlt_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              ras_pop = 1'b1;
              pc_d    = ras_top;
            end
          end else if (bus.call_req) begin
            if (ras_full) begin
              err_d   = 1'b1;
              hlt_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              ras_push = 1'b1;
              pc_d     = bus.pc_update_addr;
            end
          end else if (bus.pc_update_req) begin
            pc_d = bus.pc_update_addr;
          end
        end
      end

      ST_HALT: begin
        if (bus.resume && !err_q) begin
          hlt_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    mem_req_d    = (state_d == ST_FETCH);
    mem_addr_d   = mem_req_d ? pc_d : '0;
    exec_valid_d = (state_d == ST_EXEC);
  end

  // State and output registers; reset wins over any in-flight handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      idx_q        <= '0;
      instr_q      <= '0;
      len_q        <= '0;
      hlt_q        <= 1'b0;
      skip_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_req_q    <= 1'b1;
      mem_addr_q   <= '0;
      exec_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      instr_q      <= instr_d;
      len_q        <= len_d;
      hlt_q        <= hlt_d;
      skip_q       <= skip_d;
      err_q        <= err_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      exec_valid_q <= exec_valid_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.instr      = instr_q;
  assign bus.instr_len  = len_q;
  assign bus.exec_valid = exec_valid_q;

  assign pc    = pc_q;
  assign state = 2'(state_q);
  assign cr    = {5'b0, err_q, skip_q, hlt_q};

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
Next-generation instruction sequencer for the OSECPU core. It fetches variable-length instructions (1..MAX_WORDS words) over a ready/valid memory port with wait states, and hands a complete instruction to the execute stage with an exec_valid/exec_done handshake. It owns the PC, the HLT and SKIP control bits, and a return-address stack (RAS) for call/return. It sits between instruction memory and the register/ALU execute unit.

Parameters:
PC_W, 16, PC and memory address width; the PC wraps modulo 2^PC_W.
MAX_WORDS, 2, maximum instruction length in 32-bit words (range 1..4).
RAS_DEPTH, 4, return-address stack entries (power of two, at least 2).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
mem_req  out  1  fetch request
mem_addr  out  PC_W  fetch address; equals pc while mem_req=1, otherwise 0
mem_rdata  in  32  fetched word
mem_valid  in  1  mem_rdata is valid this cycle; sampled only in FETCH
instr  out  32*MAX_WORDS  word k held in bits [32k+31:32k]
instr_len  out  3  number of valid words in instr
exec_valid  out  1  instruction presented to the execute stage
exec_done  in  1  execute stage finished (may arrive 1..n cycles after exec_valid)
cond_lsb  in  1  LSB of the condition register, sampled at exec_done
pc_update_req  in  1  jump request, sampled at exec_done
call_req  in  1  call request, sampled at exec_done
ret_req  in  1  return request, sampled at exec_done
pc_update_addr  in  PC_W  jump or call target
resume  in  1  one-cycle pulse that leaves HALT
pc  out  PC_W  program counter
state  out  2  FSM state
cr  out  8  {5'b0, err, skip, hlt}
ras_level  out  clog2(RAS_DEPTH)+1  current RAS occupancy

Behaviour:
- Reset values: pc=0, state=FETCH, word index=0, instr=0, instr_len=0, cr=0, RAS empty, exec_valid=0. mem_req=1 from the first cycle after reset. Reset overrides everything, including in-flight mem_valid and exec_done.
- States: FETCH=0, EXEC=1, HALT=2. Value 3 is illegal and returns to FETCH.
- FETCH: mem_req=1, mem_addr=pc. No action until mem_valid=1.
  - On mem_valid: store the word in slot idx; pc <= pc+1 (wraps to 0).
  - If idx=0: instr_len <= op_len(mem_rdata[31:24]), clamped to MAX_WORDS; clear the upper instr slots.
  - If idx+1 < len: idx increments and the state stays FETCH.
  - Last word with skip=1: skip<=0, idx<=0, stay in FETCH. The whole multi-word instruction is discarded and EXEC is never entered.
  - Last word with skip=0: idx<=0, go to EXEC.
- EXEC: exec_valid=1, mem_req=0. Hold until exec_done=1, then apply updates in this priority order:
  1. op==OP_HLT: hlt<=1, go to HALT, pc unchanged.
  2. call_req and ret_req both set: err<=1, hlt<=1, go to HALT.
  3. ret_req: RAS empty gives err<=1, hlt<=1, HALT. Otherwise pop into pc.
  4. call_req: RAS full gives err<=1, hlt<=1, HALT. Otherwise push pc (already the return address) and pc<=pc_update_addr.
  5. pc_update_req: pc<=pc_update_addr.
  6. Otherwise pc unchanged.
  - Skip rule: skip<=1 iff op==OP_CND and cond_lsb=0; otherwise skip<=0.
  - Unless halted, next state is FETCH.
  - exec_valid drops in the cycle after exec_done. instr is stable throughout EXEC.
- HALT: mem_req=0, exec_valid=0, pc frozen. resume=1 with err=0 clears hlt and goes to FETCH. resume is ignored while err=1; only reset clears err.
- mem_valid in EXEC or HALT is ignored. exec_done outside EXEC is ignored.
- A jump or call to address 2^PC_W-1 followed by a fetch wraps pc to 0.

Decomposition:
- Package osecpu_pkg:
  - opcode constants OP_HLT, OP_CND, OP_LIMM32, OP_LBSET;
  - state encodings;
  - CR bit indices BIT_CR_HLT=0, BIT_CR_SKIP=1, BIT_CR_ERR=2;
  - function op_len(op): returns 2 for OP_LIMM32 and OP_LBSET, 1 for all other opcodes.
- One sub-module, ras_stack (parameter DEPTH, width PC_W): push/pop/full/empty/level, synchronous reset. Push and pop in the same cycle are not allowed.

Test Plan:
- Program with NOP at 0, LIMM32 at 1-2, HLT at 3; zero-wait memory; exec_done one cycle after exec_valid -> instr_len sequence 1,2,1; HLT with pc=4, state=HALT, cr=8'h01, mem_req=0.
- Same program with mem_valid delayed 3 cycles per word -> mem_addr held stable while waiting; same final pc=4; instr slot 1 equals the LIMM32 immediate.
- CND with cond_lsb=0 followed by LIMM32 then NOP -> both LIMM32 words fetched, no exec_valid for it, skip=0 afterwards, NOP executes next.
- CALL at 5 with target 0x20, RET at 0x20 -> pc=0x20 with ras_level=1, then pc=6 with ras_level=0. RAS_DEPTH+1 nested calls -> cr=8'h05, HALT; resume is ignored.
- HLT then a resume pulse -> hlt=0 and fetch restarts at the following pc. Reset asserted during an EXEC wait -> the next cycle has pc=0, state=FETCH, cr=0, exec_valid=0.
- PC_W=4, fetch at pc=15 -> pc wraps to 0.
